seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 21 ++
 rtl/seven_seg_scan_ctrl_bcd_to_seg.sv | 24 ++
 rtl/seven_seg_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned SIGN_DIGIT = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Two's-complement magnitude; -4096 maps to 13'h1000 without saturation.
  function automatic logic [12:0] magnitude(input logic [12:0] v);
    return v[12] ? (~v + 13'd1) : v;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd_to_seg.sv
// Combinational BCD digit to active-low segment decoder, {g,f,e,d,c,b,a}.
module bcd_to_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'b1111111;
    case (bcd)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Signed 13-bit value to 4-digit-plus-sign multiplexed seven-segment display,
// with a serial binary-to-BCD converter and a one-deep pending load slot.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [4:0]  an_n,
  output logic [6:0]  seg_n
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state;
  logic [12:0] shift_bin;
  logic [15:0] shift_bcd;
  logic [11:0] bcd_adj;
  logic [3:0]  step_cnt;
  logic        conv_neg;
  logic        pend_valid;
  logic [12:0] pend_value;
  logic [15:0] disp_bcd;
  logic        disp_neg;

  logic        start_en;
  logic [12:0] start_val;

  // Thousands nibble never reaches 5 (magnitude <= 4096), so only the lower three need add-3.
  always_comb begin
    bcd_adj = shift_bcd[11:0];
    for (int unsigned i = 0; i < 3; i++) begin
      if (shift_bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = shift_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // A load arriving in COMMIT is newer than anything pending, so it takes priority.
  always_comb begin
    start_en  = 1'b0;
    start_val = value;
    case (state)
      ST_IDLE:   start_en = load;
      ST_COMMIT: begin
        start_en = load | pend_valid;
        if (!load) start_val = pend_value;
      end
      default:   start_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_bin  <= '0;
      shift_bcd  <= '0;
      step_cnt   <= '0;
      conv_neg   <= 1'b0;
      pend_valid <= 1'b0;
      pend_value <= '0;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: ;
        ST_CONVERT: begin
          shift_bcd <= {shift_bcd[14:12], bcd_adj, shift_bin[12]};
          shift_bin <= {shift_bin[11:0], 1'b0};
          step_cnt  <= step_cnt + 4'd1;
          if (step_cnt == 4'd12) state <= ST_COMMIT;
          if (load) begin
            pend_valid <= 1'b1;
            pend_value <= value;
          end
        end
        ST_COMMIT: begin
          disp_bcd   <= shift_bcd;
          disp_neg   <= conv_neg;
          done       <= 1'b1;
          pend_valid <= 1'b0;
          if (!start_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (start_en) begin
        state     <= ST_CONVERT;
        busy      <= 1'b1;
        shift_bin <= magnitude(start_val);
        shift_bcd <= '0;
        conv_neg  <= start_val[12];
        step_cnt  <= '0;
      end
    end
  end

  logic [PW-1:0] presc;
  logic [2:0]    dig_idx;
  logic [2:0]    dig_nxt;
  logic          wrap;
  logic [3:0]    sel_bcd;
  logic          lz_blank;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_nxt;

  assign wrap = (presc == PW'(SCAN_DIV - 1));

  // an_n and seg_n are both registered from the next index so they switch together.
  always_comb begin
    dig_nxt = dig_idx;
    if (wrap) begin
      dig_nxt = (dig_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig_idx + 3'd1;
    end
  end

  always_comb begin
    sel_bcd  = 4'd0;
    lz_blank = 1'b0;
    case (dig_nxt)
      3'd0: sel_bcd = disp_bcd[3:0];
      3'd1: begin
        sel_bcd  = disp_bcd[7:4];
        lz_blank = (disp_bcd[15:4] == 12'd0);
      end
      3'd2: begin
        sel_bcd  = disp_bcd[11:8];
        lz_blank = (disp_bcd[15:8] == 8'd0);
      end
      3'd3: begin
        sel_bcd  = disp_bcd[15:12];
        lz_blank = (disp_bcd[15:12] == 4'd0);
      end
      default: sel_bcd = 4'd0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (sel_bcd),
    .seg_n (seg_dec)
  );

  always_comb begin
    if (dig_nxt == 3'(SIGN_DIGIT)) begin
      seg_nxt = disp_neg ? SEG_MINUS : SEG_BLANK;
    end else if (BLANK_LZ && lz_blank) begin
      seg_nxt = SEG_BLANK;
    end else begin
      seg_nxt = seg_dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      dig_idx <= '0;
      an_n    <= '1;
      seg_n   <= '1;
    end else begin
      presc   <= wrap ? '0 : presc + PW'(1);
      dig_idx <= dig_nxt;
      an_n    <= ~(5'b00001 << dig_nxt);
      seg_n   <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: stimulus-side model queues expected commits, a monitor checks outputs every cycle.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [12:0] value = '0;

  logic       busy0, done0, busy1, done1;
  logic [4:0] an0, an1;
  logic [6:0] seg0, seg1;

  seven_seg_scan_ctrl #(.SCAN_DIV(DIV0), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .busy(busy0), .done(done0), .an_n(an0), .seg_n(seg0)
  );

  seven_seg_scan_ctrl #(.SCAN_DIV(DIV1), .BLANK_LZ(1'b0)) u_dut_nolz (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .busy(busy1), .done(done1), .an_n(an1), .seg_n(seg1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned due;
    int          val;
  } exp_t;
  exp_t exp_q[$];

  // Active-high {g,f,e,d,c,b,a} patterns for decimal 0..9.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bit          m_inflight;
  int unsigned m_due;
  bit          m_pend;
  int          m_pend_val;
  int          shown;
  int          shown_next;
  int unsigned edges;
  bit          s_load;
  int          s_val;
  exp_t        e;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int num, input int unsigned idx, input bit blank_lz);
    int mag;
    int p;
    mag = (num < 0) ? -num : num;
    p = 1;
    for (int unsigned i = 0; i < idx; i++) p = p * 10;
    if (idx == 4) return (num < 0) ? 7'b0111111 : 7'b1111111;
    if (blank_lz && idx > 0 && mag < p) return 7'b1111111;
    return ~seg_tab[(mag / p) % 10];
  endfunction

  function automatic logic [4:0] exp_an(input int unsigned div);
    int unsigned idx;
    idx = (edges / div) % 5;
    return 5'h1F ^ (5'd1 << idx);
  endfunction

  task automatic start_conv(input int val);
    m_inflight = 1'b1;
    m_due = cyc + 14;
    exp_q.push_back('{cyc + 14, val});
  endtask

  always @(posedge clk) begin
    cyc++;
    s_load = load;
    s_val  = int'($signed(value));
    if (!reset_n) begin
      m_inflight = 1'b0;
      m_pend     = 1'b0;
      shown      = 0;
      shown_next = 0;
      edges      = 0;
      exp_q.delete();
    end else begin
      edges++;
      if (m_inflight && cyc == m_due) begin
        if (s_load) start_conv(s_val);
        else if (m_pend) start_conv(m_pend_val);
        else m_inflight = 1'b0;
        m_pend = 1'b0;
      end else if (m_inflight) begin
        if (s_load) begin
          m_pend = 1'b1;
          m_pend_val = s_val;
        end
      end else if (s_load) begin
        start_conv(s_val);
      end
    end
    #1;
    if (!reset_n) begin
      check("reset_busy", busy0, 0);
      check("reset_done", done0, 0);
      check("reset_an", an0, 5'h1F);
      check("reset_seg", seg0, 7'h7F);
    end else begin
      check("busy", busy0, m_inflight);
      check("busy_nolz", busy1, m_inflight);
      check("an", an0, exp_an(DIV0));
      check("an_nolz", an1, exp_an(DIV1));
      check("seg", seg0, exp_seg(shown, (edges / DIV0) % 5, 1'b1));
      check("seg_nolz", seg1, exp_seg(shown, (edges / DIV1) % 5, 1'b0));
      if (done0) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", int'(cyc), int'(e.due));
          shown_next = e.val;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("done_missing", 0, 1);
      end
      shown = shown_next;
    end
  end

  task automatic drive(input bit l, input logic [12:0] v);
    @(negedge clk);
    load  = l;
    value = v;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b0, value);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(30);
    drive(1'b1, 13'd1234);   idle(40);
    drive(1'b1, 13'h1FF9);   idle(40);
    drive(1'b1, 13'h1000);   idle(40);
    // Overlapping loads: 77 is displaced from the pending slot by 88.
    drive(1'b1, 13'd5);      idle(2);
    drive(1'b1, 13'd77);     idle(1);
    drive(1'b1, 13'd88);     idle(50);
    // Load landing exactly on the commit edge restarts with no idle gap.
    drive(1'b1, 13'd100);    idle(13);
    drive(1'b1, 13'd200);    idle(40);
    // Reset mid-conversion with a pending value.
    drive(1'b1, 13'd999);    idle(3);
    drive(1'b1, 13'd321);    idle(2);
    @(negedge clk);
    load    = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(40);
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) drive(1'b1, 13'($urandom));
      else idle(1);
    end
    idle(60);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
